seg_display_ctrl: RTL and testbench
===================================

Name: seg_display_ctrl

Overview:
- Parametrised display back-end for the soft core. It converts a captured register value (e.g. out_reg) into active-low 7-segment patterns for NUM_DIGITS digits.
- Three modes: hex, unsigned decimal, signed decimal. Decimal conversion is a sequential shift-add-3 (double-dabble) engine.
- Supports leading-zero blanking and overflow indication.
- Replaces the fixed combinational HEX0..HEX5 decode in the core top.

Parameters:
- DATA_W, 32, width of the input value.
- NUM_DIGITS, 6, number of 7-segment digits driven.
- BCD_DIGITS, 10, derived localparam (ceil(DATA_W*log10 2)), internal BCD width in digits.

Ports:
- KEY0  input  1  clock (board KEY[0] domain, rising edge)
- KEY1  input  1  asynchronous active-low reset
- data_in  input  DATA_W  value to display
- load  input  1  capture strobe, sampled on the rising edge of KEY0
- mode  input  2  0=hex, 1=unsigned dec, 2=signed dec, 3=reserved (treated as hex)
- blank_lz  input  1  1=blank leading zero digits
- hex_out  output  7*NUM_DIGITS  digit i in bits [7i+6:7i], active-low, segment order g..a
- busy  output  1  conversion in progress
- ovf  output  1  value not representable in NUM_DIGITS (drive to LEDR[9] at top)

Behaviour:
- Reset (KEY1=0, asynchronous): hex_out all 7'h7F (blank), busy=0, ovf=0, FSM to IDLE, BCD and shift registers cleared.
  - Reset mid-conversion aborts the conversion. Display stays blank until the next completed load.
- FSM states: IDLE, CONV, LATCH.
- IDLE:
  - load=1 with mode hex: hex_out and ovf update on that same edge; busy stays 0.
  - load=1 with mode decimal: capture the magnitude and sign, then go to CONV.
    - Unsigned mode: magnitude = data_in.
    - Signed mode: if data_in[DATA_W-1]=1, magnitude = two's-complement negation, neg=1.
- CONV:
  - DATA_W cycles, one bit per cycle, MSB first.
  - Each cycle, add 3 to every BCD digit >=5 before the shift.
  - Bit counter runs 0..DATA_W-1, then go to LATCH.
- LATCH: one cycle; update hex_out and ovf, then go to IDLE.
  - busy=1 in CONV and LATCH, so it is high for exactly DATA_W+1 cycles.
  - hex_out changes on the edge where busy falls.
- load while busy=1 is ignored (no queueing). hex_out holds its previous value throughout the conversion.
- Hex mode: digit i = data_in[4i+3:4i].
  - ovf=1 if any bit at or above 4*NUM_DIGITS is set.
- Decimal ovf conditions:
  - Unsigned: any BCD digit at index >= NUM_DIGITS is nonzero.
  - Signed with neg=1: any BCD digit at index >= NUM_DIGITS-1 is nonzero (one digit is reserved for the minus sign).
  - Signed with neg=0: same rule as unsigned.
  - Most-negative input (0x80000000) converts to magnitude 2147483648 and sets ovf.
- On ovf=1, every digit shows 'E' (7'h06) and blank_lz is ignored.
- Leading-zero blanking (blank_lz=1):
  - Digits above the most significant nonzero digit are blanked (7'h7F).
  - Digit 0 is always shown, so a value of 0 displays a single "0".
- Minus sign (7'h3F) placement:
  - blank_lz=1: in the digit directly left of the most significant shown digit.
  - blank_lz=0: in digit NUM_DIGITS-1.
- Glyphs 0-F:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E

Decomposition:
- Package seg_pkg:
  - glyph constant table (16 entries plus BLANK, MINUS, ERR)
  - mode encodings MODE_HEX, MODE_UDEC, MODE_SDEC
  - FSM state encodings
- Sub-module bin2bcd_seq(DATA_W, BCD_DIGITS):
  - ports: start, bin, busy, done, bcd
  - contains the shift-add-3 datapath and bit counter
- The top block owns the mode/sign handling, overflow, blanking and glyph mapping.

Test Plan:
- Hex mode, data_in=0x00ABCDEF, load 1 cycle -> on the same edge, hex_out digits 5..0 = 08,03,46,21,06,0E; ovf=0; busy never rises.
- Unsigned dec, data_in=123456 -> busy high for 33 cycles; then digits 5..0 = 79,24,30,19,12,02; ovf=0.
- Signed dec, blank_lz=1, data_in=-42 (0xFFFFFFD6) -> digits 5..3 = 7F, digit2 = 3F, digit1 = 19, digit0 = 24.
- Unsigned dec, data_in=1000000 -> all digits 06, ovf=1. Then hex 0x1000000 -> ovf=1, digits show 'E'. Then hex 0 with blank_lz=1 -> digit0 = 40, others 7F, ovf=0.
- Load of 999999 while busy from a prior conversion of 5 -> second load ignored; display shows 5 (with blank_lz=0: 40,40,40,40,40,12).
- Assert KEY1=0 at cycle 10 of a conversion of 777 -> immediately busy=0 and hex_out all 7F. After release, a new load of 777 displays 7F,7F,7F,78,78,78 with blank_lz=1.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg: shared constants for the 7-segment display back-end.
//   - active-low glyph table (segment order g..a) plus BLANK / MINUS / ERR
//   - display mode encodings
//   - controller FSM state encoding
//   - helper that sizes the internal BCD register from the binary width
`timescale 1ns/1ps
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_ERR   = 7'h06;

  localparam logic [6:0] SEG_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam logic [1:0] MODE_HEX  = 2'd0;
  localparam logic [1:0] MODE_UDEC = 2'd1;
  localparam logic [1:0] MODE_SDEC = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CONV  = 2'd1,
    ST_LATCH = 2'd2
  } state_e;

  // ceil(w * log10(2)) using a 5-digit fixed-point log10(2).
  function automatic int bcd_digits(input int w);
    return (w * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-add-3 (double-dabble) binary-to-BCD converter.
//   clk_i    clock
//   rst_ni   asynchronous active-low reset
//   start_i  capture bin_i and begin a conversion (ignored while busy)
//   bin_i    DATA_W-bit unsigned value
//   busy_o   high while shifting (DATA_W cycles)
//   done_o   high during the cycle whose edge performs the final shift
//   bcd_o    BCD_DIGITS packed BCD digits, digit 0 in bits [3:0]
`timescale 1ns/1ps
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int BCD_DIGITS = 10
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [DATA_W-1:0]       bin_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [4*BCD_DIGITS-1:0] bcd_o
);

  localparam int BCDW = 4 * BCD_DIGITS;
  localparam int CW   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BCDW-1:0]   bcd_q, bcd_d, bcd_adj;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              last;

  assign last = busy_q && (cnt_q == LAST_BIT);

  // Pre-shift correction: any digit >= 5 would become >= 10 after doubling.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    shift_d = shift_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    if (start_i && !busy_q) begin
      shift_d = bin_i;
      bcd_d   = '0;
      cnt_d   = '0;
      busy_d  = 1'b1;
    end else if (busy_q) begin
      bcd_d   = {bcd_adj[BCDW-2:0], shift_q[DATA_W-1]};
      shift_d = shift_q << 1;
      cnt_d   = cnt_q + 1'b1;
      if (last) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = last;
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl: converts a captured value into active-low 7-segment
// patterns for NUM_DIGITS digits in hex, unsigned or signed decimal.
//   KEY0      clock (rising edge)
//   KEY1      asynchronous active-low reset
//   data_in   value to display, sampled with load
//   load      capture strobe (ignored while busy)
//   mode      0=hex, 1=unsigned dec, 2=signed dec, 3=hex
//   blank_lz  blank leading zero digits
//   hex_out   digit i in bits [7i+6:7i], segments g..a, active-low
//   busy      decimal conversion in progress (DATA_W+1 cycles)
//   ovf       value does not fit the display; all digits show 'E'
//
// state    | meaning
// ST_IDLE  | waiting for load; hex loads update the display directly
// ST_CONV  | double-dabble engine shifting in the magnitude
// ST_LATCH | BCD result final; display and ovf update on leaving
`timescale 1ns/1ps
module seg_display_ctrl
  import seg_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int NUM_DIGITS = 6
) (
  input  logic                    KEY0,
  input  logic                    KEY1,
  input  logic [DATA_W-1:0]       data_in,
  input  logic                    load,
  input  logic [1:0]              mode,
  input  logic                    blank_lz,
  output logic [7*NUM_DIGITS-1:0] hex_out,
  output logic                    busy,
  output logic                    ovf
);

  localparam int BCD_DIGITS = bcd_digits(DATA_W);
  localparam int BCDW       = 4 * BCD_DIGITS;
  localparam int NIBW       = 4 * NUM_DIGITS;
  localparam int SEGW       = 7 * NUM_DIGITS;

  state_e state_q, state_d;

  logic [SEGW-1:0] hex_q, hex_d, seg_render;
  logic            ovf_q, ovf_d;
  logic            neg_q, neg_d;
  logic            blank_q, blank_d;

  logic              is_dec;
  logic              neg_in;
  logic [DATA_W-1:0] mag;
  logic              start;
  logic              upd_hex;
  logic              upd_dec;
  logic              conv_busy;
  logic              conv_done;
  logic [BCDW-1:0]   bcd;

  // ---------------------------------------------------------------- input side
  assign is_dec = (mode == MODE_UDEC) || (mode == MODE_SDEC);
  assign neg_in = (mode == MODE_SDEC) && data_in[DATA_W-1];
  // The most-negative value negates to itself, which read unsigned is the
  // correct magnitude.
  assign mag    = neg_in ? -data_in : data_in;

  bin2bcd_seq #(
    .DATA_W    (DATA_W),
    .BCD_DIGITS(BCD_DIGITS)
  ) u_bin2bcd (
    .clk_i  (KEY0),
    .rst_ni (KEY1),
    .start_i(start),
    .bin_i  (mag),
    .busy_o (conv_busy),
    .done_o (conv_done),
    .bcd_o  (bcd)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge KEY0 or negedge KEY1) begin
    if (!KEY1) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (load && is_dec) state_d = ST_CONV;
      ST_CONV:  if (conv_done)      state_d = ST_LATCH;
      ST_LATCH:                     state_d = ST_IDLE;
      default:                      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    start   = 1'b0;
    upd_hex = 1'b0;
    upd_dec = 1'b0;
    case (state_q)
      ST_IDLE: begin
        start   = load && is_dec;
        upd_hex = load && !is_dec;
      end
      ST_LATCH: upd_dec = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- digit sources
  // Zero-extend so the low NUM_DIGITS nibbles and the overflow bits above
  // them can be sliced regardless of the relative widths.
  logic [NIBW+DATA_W-1:0] data_ext;
  logic [NIBW+BCDW-1:0]   bcd_ext;
  logic [NIBW-1:0]        hex_nib, dec_nib, src_nib;
  logic                   hex_ovf, dec_ovf_u, dec_ovf_n;
  logic                   src_ovf, src_neg, src_blank;

  assign data_ext  = {{NIBW{1'b0}}, data_in};
  assign bcd_ext   = {{NIBW{1'b0}}, bcd};
  assign hex_nib   = data_ext[NIBW-1:0];
  assign dec_nib   = bcd_ext[NIBW-1:0];
  assign hex_ovf   = |data_ext[NIBW+DATA_W-1:NIBW];
  assign dec_ovf_u = |bcd_ext[NIBW+BCDW-1:NIBW];
  // A negative value gives up its top digit to the minus sign.
  assign dec_ovf_n = |bcd_ext[NIBW+BCDW-1:NIBW-4];

  assign src_nib   = upd_dec ? dec_nib : hex_nib;
  assign src_ovf   = upd_dec ? (neg_q ? dec_ovf_n : dec_ovf_u) : hex_ovf;
  assign src_neg   = upd_dec && neg_q;
  assign src_blank = upd_dec ? blank_q : blank_lz;

  // ---------------------------------------------------------------- glyph render
  always_comb begin
    int msd;
    msd        = 0;
    seg_render = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (src_nib[4*i +: 4] != 4'd0) msd = i;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (src_ovf) begin
        seg_render[7*i +: 7] = SEG_ERR;
      end else if (src_neg && ((src_blank && (i == msd + 1)) ||
                               (!src_blank && (i == NUM_DIGITS - 1)))) begin
        seg_render[7*i +: 7] = SEG_MINUS;
      end else if (src_blank && (i > msd)) begin
        seg_render[7*i +: 7] = SEG_BLANK;
      end else begin
        seg_render[7*i +: 7] = SEG_GLYPH[src_nib[4*i +: 4]];
      end
    end
  end

  // ---------------------------------------------------------------- display regs
  always_comb begin
    hex_d   = hex_q;
    ovf_d   = ovf_q;
    neg_d   = neg_q;
    blank_d = blank_q;
    if (upd_hex || upd_dec) begin
      hex_d = seg_render;
      ovf_d = src_ovf;
    end
    if (start) begin
      neg_d   = neg_in;
      blank_d = blank_lz;
    end
  end

  always_ff @(posedge KEY0 or negedge KEY1) begin
    if (!KEY1) begin
      hex_q   <= {NUM_DIGITS{SEG_BLANK}};
      ovf_q   <= 1'b0;
      neg_q   <= 1'b0;
      blank_q <= 1'b0;
    end else begin
      hex_q   <= hex_d;
      ovf_q   <= ovf_d;
      neg_q   <= neg_d;
      blank_q <= blank_d;
    end
  end

  assign hex_out = hex_q;
  assign ovf     = ovf_q;
  assign busy    = conv_busy || (state_q != ST_IDLE);

endmodule

// File: tb/tb_seg_display_ctrl.sv
`timescale 1ns/1ps
module tb_seg_display_ctrl;

  logic        KEY0 = 1'b0;
  logic        KEY1 = 1'b0;
  logic [31:0] data_in = '0;
  logic        load = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        blank_lz = 1'b0;
  logic [41:0] hex_out;
  logic        busy;
  logic        ovf;

  int checks = 0;
  int failures = 0;
  logic [41:0] exp_prev;

  seg_display_ctrl #(.DATA_W(32), .NUM_DIGITS(6)) dut (
    .KEY0    (KEY0),
    .KEY1    (KEY1),
    .data_in (data_in),
    .load    (load),
    .mode    (mode),
    .blank_lz(blank_lz),
    .hex_out (hex_out),
    .busy    (busy),
    .ovf     (ovf)
  );

  always #5 KEY0 = ~KEY0;

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] data;
    logic        blank;
    logic [41:0] exp_hex;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[14];

  localparam logic [41:0] ALL_E     = {6{7'h06}};
  localparam logic [41:0] ALL_BLANK = {6{7'h7F}};

  function automatic logic [41:0] pk(input logic [6:0] d5, d4, d3, d2, d1, d0);
    return {d5, d4, d3, d2, d1, d0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic do_load(input logic [1:0] m, input logic [31:0] d, input logic b);
    @(negedge KEY0);
    mode = m; data_in = d; blank_lz = b; load = 1'b1;
    @(posedge KEY0);
    #1;
    load = 1'b0;
  endtask

  // Counts samples with busy=1 starting at the current sample; checks the
  // display holds its previous value throughout.
  task automatic wait_busy(input int start_cnt, output int cnt, output logic hold_ok);
    cnt = start_cnt;
    hold_ok = 1'b1;
    while (busy && cnt < 100) begin
      if (hex_out !== exp_prev) hold_ok = 1'b0;
      cnt++;
      @(posedge KEY0);
      #1;
    end
  endtask

  task automatic run_vec(input int idx);
    int cnt;
    logic hold_ok;
    logic busy_seen;
    vec_t v;
    v = vecs[idx];
    do_load(v.mode, v.data, v.blank);
    if (v.mode == 2'd1 || v.mode == 2'd2) begin
      wait_busy(0, cnt, hold_ok);
      chk($sformatf("v%0d_busy_cycles", idx), 64'(cnt), 64'd33);
      chk($sformatf("v%0d_hold", idx), 64'(hold_ok), 64'd1);
    end else begin
      busy_seen = busy;
      chk($sformatf("v%0d_hex_same_edge", idx), 64'(hex_out), 64'(v.exp_hex));
      repeat (3) begin
        @(posedge KEY0); #1;
        busy_seen = busy_seen | busy;
      end
      chk($sformatf("v%0d_busy_never", idx), 64'(busy_seen), 64'd0);
    end
    chk($sformatf("v%0d_hex", idx), 64'(hex_out), 64'(v.exp_hex));
    chk($sformatf("v%0d_ovf", idx), 64'(ovf), 64'(v.exp_ovf));
    exp_prev = v.exp_hex;
  endtask

  initial begin
    int cnt;
    logic hold_ok;

    vecs[0]  = '{2'd0, 32'h00ABCDEF, 1'b0, pk(7'h08,7'h03,7'h46,7'h21,7'h06,7'h0E), 1'b0};
    vecs[1]  = '{2'd1, 32'd123456,   1'b0, pk(7'h79,7'h24,7'h30,7'h19,7'h12,7'h02), 1'b0};
    vecs[2]  = '{2'd2, 32'hFFFFFFD6, 1'b1, pk(7'h7F,7'h7F,7'h7F,7'h3F,7'h19,7'h24), 1'b0};
    vecs[3]  = '{2'd1, 32'd1000000,  1'b0, ALL_E, 1'b1};
    vecs[4]  = '{2'd0, 32'h01000000, 1'b0, ALL_E, 1'b1};
    vecs[5]  = '{2'd0, 32'h00000000, 1'b1, pk(7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h40), 1'b0};
    vecs[6]  = '{2'd2, 32'h80000000, 1'b0, ALL_E, 1'b1};
    vecs[7]  = '{2'd2, 32'hFFFFFFD6, 1'b0, pk(7'h3F,7'h40,7'h40,7'h40,7'h19,7'h24), 1'b0};
    vecs[8]  = '{2'd2, -32'sd99999,  1'b1, pk(7'h3F,7'h10,7'h10,7'h10,7'h10,7'h10), 1'b0};
    vecs[9]  = '{2'd2, -32'sd100000, 1'b1, ALL_E, 1'b1};
    vecs[10] = '{2'd1, 32'd999999,   1'b0, {6{7'h10}}, 1'b0};
    vecs[11] = '{2'd1, 32'd0,        1'b1, pk(7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h40), 1'b0};
    vecs[12] = '{2'd3, 32'h00123456, 1'b0, pk(7'h79,7'h24,7'h30,7'h19,7'h12,7'h02), 1'b0};
    vecs[13] = '{2'd2, 32'd305,      1'b1, pk(7'h7F,7'h7F,7'h7F,7'h30,7'h40,7'h12), 1'b0};

    // reset state
    #12;
    chk("rst_hex", 64'(hex_out), 64'(ALL_BLANK));
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    exp_prev = ALL_BLANK;
    @(negedge KEY0);
    KEY1 = 1'b1;

    for (int i = 0; i < 14; i++) run_vec(i);

    // second load while busy is ignored
    do_load(2'd1, 32'd5, 1'b0);
    repeat (3) @(posedge KEY0);
    @(negedge KEY0);
    data_in = 32'd999999; load = 1'b1;
    @(posedge KEY0);
    #1;
    load = 1'b0;
    chk("ign_busy_mid", 64'(busy), 64'd1);
    wait_busy(4, cnt, hold_ok);
    chk("ign_busy_cycles", 64'(cnt), 64'd33);
    chk("ign_hold", 64'(hold_ok), 64'd1);
    chk("ign_hex", 64'(hex_out), 64'(pk(7'h40,7'h40,7'h40,7'h40,7'h40,7'h12)));
    exp_prev = pk(7'h40,7'h40,7'h40,7'h40,7'h40,7'h12);
    repeat (40) @(posedge KEY0);
    #1;
    chk("ign_no_restart_busy", 64'(busy), 64'd0);
    chk("ign_no_restart_hex", 64'(hex_out), 64'(exp_prev));

    // reset in the middle of a conversion
    do_load(2'd1, 32'd777, 1'b1);
    repeat (10) @(posedge KEY0);
    #3;
    KEY1 = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hex", 64'(hex_out), 64'(ALL_BLANK));
    chk("abort_ovf", 64'(ovf), 64'd0);
    exp_prev = ALL_BLANK;
    repeat (2) @(negedge KEY0);
    KEY1 = 1'b1;
    repeat (5) @(posedge KEY0);
    #1;
    chk("abort_stay_blank", 64'(hex_out), 64'(ALL_BLANK));
    chk("abort_stay_idle", 64'(busy), 64'd0);
    do_load(2'd1, 32'd777, 1'b1);
    wait_busy(0, cnt, hold_ok);
    chk("post_busy_cycles", 64'(cnt), 64'd33);
    chk("post_hold", 64'(hold_ok), 64'd1);
    chk("post_hex", 64'(hex_out), 64'(pk(7'h7F,7'h7F,7'h7F,7'h78,7'h78,7'h78)));
    chk("post_ovf", 64'(ovf), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
